// File: rtl/instr_ring_meter.sv
// Ring/chain edge meter: arms the ring path, settles, then counts synchronised
// rising edges of ring_in over a programmable window and freezes the result.
//
// state   | meaning
// IDLE    | waiting for start, ring path disabled
// ARM     | ring enabled, settle counter running
// MEASURE | window counter running, edges counted
// DONE    | result frozen, done held until reset or next start
module instr_ring_meter #(
   parameter int COUNT_W       = 32,
   parameter int SYNC_STAGES   = 2,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   input  logic               start,
   input  logic [31:0]        window_cycles,
   input  logic               ring_in,
   output logic               ring_en,
   output logic               busy,
   output logic               done,
   output logic [COUNT_W-1:0] count,
   output logic               overflow
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [7:0]             settle_q, settle_d;
   logic [31:0]            win_q, win_d;
   logic [31:0]            win_cnt_q, win_cnt_d;
   logic [COUNT_W-1:0]     count_q, count_d;
   logic                   overflow_q, overflow_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   edge_prev_q, edge_prev_d;
   logic                   edge_fire;

   assign edge_fire = sync_q[SYNC_STAGES-1] & ~edge_prev_q;

   always_comb begin
      state_d     = state_q;
      settle_d    = settle_q;
      win_d       = win_q;
      win_cnt_d   = win_cnt_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      sync_d      = {sync_q[SYNC_STAGES-2:0], ring_in};
      edge_prev_d = sync_q[SYNC_STAGES-1];

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               win_d      = window_cycles;
               count_d    = '0;
               overflow_d = 1'b0;
               settle_d   = 8'(SETTLE_CYCLES);
               state_d    = ARM;
            end
         end
         ARM: begin
            settle_d = settle_q - 8'd1;
            if (settle_q == 8'd1) begin
               if (win_q == 32'd0) begin
                  state_d = DONE;
               end else begin
                  state_d   = MEASURE;
                  win_cnt_d = win_q;
               end
            end
         end
         MEASURE: begin
            win_cnt_d = win_cnt_q - 32'd1;
            // saturate rather than wrap; overflow is sticky until the next start
            if (edge_fire) begin
               if (&count_q) overflow_d = 1'b1;
               else          count_d    = count_q + COUNT_W'(1);
            end
            if (win_cnt_q == 32'd1) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == ARM) || (state_d == MEASURE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q     <= IDLE;
         settle_q    <= '0;
         win_q       <= '0;
         win_cnt_q   <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         sync_q      <= '0;
         edge_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         settle_q    <= settle_d;
         win_q       <= win_d;
         win_cnt_q   <= win_cnt_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         sync_q      <= sync_d;
         edge_prev_q <= edge_prev_d;
      end
   end

   assign ring_en  = busy_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign count    = count_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_instr_ring_meter.sv
// Directed bench for instr_ring_meter: a 32-bit and a 4-bit counter instance
// share stimulus so saturation is checked alongside exact counts.
module tb_instr_ring_meter;

   localparam int S = 4;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] window_cycles;
   logic        ring_in;

   logic        ring_en32, busy32, done32, ovf32;
   logic [31:0] count32;
   logic        ring_en4, busy4, done4, ovf4;
   logic [3:0]  count4;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int cyc       = 0;
   int mode      = 0;   // 0: constant low, 1: period 4 (2 high/2 low), 2: period 2
   int phase     = 0;

   instr_ring_meter #(.COUNT_W(32), .SYNC_STAGES(2), .SETTLE_CYCLES(S)) dut32 (
      .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .window_cycles(window_cycles),
      .ring_in(ring_in), .ring_en(ring_en32), .busy(busy32), .done(done32),
      .count(count32), .overflow(ovf32));

   instr_ring_meter #(.COUNT_W(4), .SYNC_STAGES(2), .SETTLE_CYCLES(S)) dut4 (
      .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .window_cycles(window_cycles),
      .ring_in(ring_in), .ring_en(ring_en4), .busy(busy4), .done(done4),
      .count(count4), .overflow(ovf4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc++;
      #1;
      case (mode)
         1:       ring_in = (((cyc + phase) % 4) < 2);
         2:       ring_in = (((cyc + phase) % 2) == 0);
         default: ring_in = 1'b0;
      endcase
   end

   task automatic chk(input string name, input longint act, input longint exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_ring_en"}, ring_en32, 0);
      chk({name, "_busy"}, busy32, 0);
      chk({name, "_done"}, done32, 0);
      chk({name, "_count"}, count32, 0);
      chk({name, "_ovf"}, ovf32, 0);
      chk({name, "_count4"}, count4, 0);
      chk({name, "_ovf4"}, ovf4, 0);
   endtask

   // k counts edges after the accepting edge E (k=0 is E itself)
   task automatic start_run(input logic [31:0] w, input int maxk,
                            output int first_done, output int en_high);
      @(negedge clk);
      start = 1'b1;
      window_cycles = w;
      @(posedge clk); #1;
      start = 1'b0;
      first_done = -1;
      en_high = 0;
      for (int k = 0; k <= maxk; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         if (ring_en32) en_high++;
         if (done32) begin first_done = k; break; end
      end
   endtask

   typedef struct {
      logic [31:0] win;
      int          mode;
      int          phase;
      int          c32;
      int          o32;
      int          c4;
      int          o4;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int fd, eh, k;

      vecs[0] = '{32'd100, 0, 0,  0, 0,  0, 0};
      vecs[1] = '{32'd100, 1, 0, 25, 0, 15, 1};
      vecs[2] = '{32'd100, 1, 1, 25, 0, 15, 1};
      vecs[3] = '{32'd100, 1, 2, 25, 0, 15, 1};
      vecs[4] = '{32'd100, 1, 3, 25, 0, 15, 1};
      vecs[5] = '{32'd40,  2, 0, 20, 0, 15, 1};
      vecs[6] = '{32'd10,  0, 0,  0, 0,  0, 0};
      vecs[7] = '{32'd8,   1, 1,  2, 0,  2, 0};

      rst = 1'b1;
      start = 1'b0;
      window_cycles = '0;
      ring_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");

      // start coincident with reset: reset wins
      @(negedge clk);
      start = 1'b1;
      window_cycles = 32'd20;
      @(posedge clk); #1;
      start = 1'b0;
      chk_all_zero("rst_and_start");
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(posedge clk);

      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         mode = vecs[i].mode;
         phase = vecs[i].phase;
         start_run(vecs[i].win, S + int'(vecs[i].win) + 10, fd, eh);
         chk($sformatf("v%0d_done_edge", i), fd, S + int'(vecs[i].win));
         chk($sformatf("v%0d_ring_en_cycles", i), eh, S + int'(vecs[i].win));
         chk($sformatf("v%0d_count", i), count32, vecs[i].c32);
         chk($sformatf("v%0d_ovf", i), ovf32, vecs[i].o32);
         chk($sformatf("v%0d_count4", i), count4, vecs[i].c4);
         chk($sformatf("v%0d_ovf4", i), ovf4, vecs[i].o4);
         chk($sformatf("v%0d_busy_after", i), busy32, 0);
         repeat (3) @(posedge clk);
      end

      // zero window
      @(negedge clk);
      mode = 1;
      start_run(32'd0, S + 10, fd, eh);
      chk("zero_done_edge", fd, S);
      chk("zero_ring_en_cycles", eh, S);
      chk("zero_count", count32, 0);
      chk("zero_ovf4", ovf4, 0);

      // start pulsed during MEASURE is ignored
      @(negedge clk);
      mode = 0;
      start = 1'b1;
      window_cycles = 32'd50;
      @(posedge clk); #1;
      start = 1'b0;
      fd = -1;
      for (k = 1; k <= S + 70; k++) begin
         @(posedge clk); #1;
         if (k == S + 10) begin
            chk("busy_start_in_measure", busy32, 1);
            @(negedge clk);
            start = 1'b1;
            window_cycles = 32'd5;
            @(posedge clk); #1;
            start = 1'b0;
            k++;
         end
         if (done32) begin fd = k; break; end
      end
      chk("busy_start_done_edge", fd, S + 50);

      // reset in MEASURE cycle 60, then a fresh run
      @(negedge clk);
      mode = 1;
      start = 1'b1;
      window_cycles = 32'd200;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (S + 59) @(posedge clk);
      #1;
      chk("pre_reset_busy", busy32, 1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk_all_zero("mid_reset");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_after_reset_busy", busy32, 0);
      start_run(32'd100, S + 110, fd, eh);
      chk("post_reset_done_edge", fd, S + 100);
      chk("post_reset_count", count32, 25);
      chk("post_reset_ovf", ovf32, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/instr_ring_meter.md
# instr_ring_meter

Measurement controller directly downstream of the instrumented adder's ring/chain output. On a start command it enables the oscillating path, waits a settle period, then counts rising edges of the asynchronous `chain_out` signal over a programmable number of `wb_clk_i` cycles. It presents the frozen count, a saturation flag and status to the logic-analyser side of the wrapper.

## Interface

Parameters:
- `COUNT_W`, 32: width of the edge counter and `count` output.
- `SYNC_STAGES`, 2: synchroniser depth for `ring_in`; legal values are 2 to 4.
- `SETTLE_CYCLES`, 4: cycles in ARM before counting starts; legal values are 1 to 255.

Ports:
- `wb_clk_i`, input, 1: the single clock.
- `wb_rst_i`, input, 1: synchronous, active-high reset.
- `start`, input, 1: single-cycle start request.
- `window_cycles`, input, 32: measurement window length, sampled when a start is accepted.
- `ring_in`, input, 1: asynchronous oscillator/chain output, normally the adder's `chain_out`.
- `ring_en`, output, 1: enables the ring path; high only in ARM and MEASURE.
- `busy`, output, 1: high in ARM and MEASURE.
- `done`, output, 1: sticky result-valid flag; cleared by reset or by the next accepted start.
- `count`, output, COUNT_W: rising edges counted in the window.
- `overflow`, output, 1: the count saturated.

## Operation

- States are IDLE, ARM, MEASURE and DONE. Reset enters IDLE.
- IDLE or DONE with `start`=1:
  - Latch `window_cycles` into `win_q`.
  - Clear `count`, `overflow` and `done`.
  - Load the settle counter with SETTLE_CYCLES and go to ARM.
- `start` in ARM or MEASURE is ignored: no restart and no change to the latched window.
- ARM:
  - Decrement the settle counter each cycle.
  - At the end of the SETTLE_CYCLES-th ARM cycle, go to MEASURE with the window counter set to `win_q`.
  - If `win_q`=0, go straight to DONE instead, with `count`=0.
- MEASURE:
  - Every cycle, decrement the window counter.
  - Increment `count` on any cycle where the edge detector fires.
  - When the window counter reaches 0, the cycle just ended is the last counted cycle; go to DONE.
- DONE: hold `count` and `overflow`, keep `done`=1, and stay until reset or an accepted start.
- Synchroniser: `ring_in` passes through SYNC_STAGES flops. Registers in the synchroniser chain, the edge detector, and all outputs are reset to 0 by `wb_rst_i`.
- Edge detector: fires when the last synchroniser stage is 1 and the registered copy of that stage is 0.
  - The synchroniser and edge detector run in every state.
  - Edges are counted only in MEASURE.
- Arithmetic: `count` saturates at 2^COUNT_W−1. An edge arriving at saturation leaves `count` unchanged and sets `overflow`, which stays set until the next start.
- Ring frequency must be below f(`wb_clk_i`)/2 for exact counts. Faster rings undercount; no error is flagged for that.

## Timing

- Reset values:
  - `ring_en`=0, `busy`=0, `done`=0, `count`=0, `overflow`=0.
  - State is IDLE; all internal counters are 0.
- All outputs are registered.
- With start accepted at edge E:
  - `ring_en` and `busy` go high after E.
  - MEASURE spans cycles E+SETTLE_CYCLES+1 through E+SETTLE_CYCLES+`win_q`.
  - `done`=1, `busy`=0 and `ring_en`=0 after edge E+SETTLE_CYCLES+`win_q`.
- Zero window: `done` rises after edge E+SETTLE_CYCLES.
- Edge-to-count latency: SYNC_STAGES+1 cycles. Edges reaching the detector after the window closes are not counted.
- Simultaneous `start` and `wb_rst_i`: reset wins.
- `wb_rst_i` mid-operation: at the next edge, return to IDLE with every output at its reset value. The prior result is lost.
- `start` in DONE: `done` drops the following cycle and the block re-enters ARM.
- `win_q`=0xFFFF_FFFF is legal; MEASURE then lasts 2^32−1 cycles.

## Test plan

- Constant input: `ring_in`=0, window 100, SETTLE_CYCLES=4, start at cycle 10.
  - `ring_en` is high for cycles 11–114.
  - `done` rises after edge 114.
  - `count`=0, `overflow`=0.
- Square wave: `ring_in` has period 4 cycles (high 2, low 2), window 100.
  - `count`=25 for every starting phase, checked over 4 phase offsets.
- Saturation: COUNT_W=4, `ring_in` period 2, window 40.
  - `count`=15, `overflow`=1.
  - A following start with `ring_in`=0 gives `count`=0, `overflow`=0.
- Zero window and busy start:
  - Window 0: `done` rises after edge start+SETTLE_CYCLES, `count`=0, `ring_en` pulses high for SETTLE_CYCLES cycles.
  - Pulse `start` with `window_cycles`=5 during MEASURE of a window-50 run: the run still lasts 50 cycles.
- Reset mid-measure: `ring_in` period 4, window 200, assert `wb_rst_i` for 1 cycle at MEASURE cycle 60.
  - Next cycle: all outputs are 0 and state is IDLE.
  - A new window-100 run then yields `count`=25.
